// File: rtl/link_vc_scheduler_if.sv
// rtl/link_vc_scheduler_if.sv - flit types and requester/link bundle for link_vc_scheduler
package noc_params;
  localparam int VC_NUM  = 4;
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_W-1:0]    data;
  } flit_t;
endpackage

interface link_vc_scheduler_if #(
  parameter int VC_NUM = noc_params::VC_NUM
);
  import noc_params::*;

  flit_t [VC_NUM-1:0] vc_flit;
  logic  [VC_NUM-1:0] vc_valid;
  logic  [VC_NUM-1:0] vc_ready;
  flit_t              data;
  logic               is_valid;
  logic  [VC_NUM-1:0] is_on_off;
  logic  [VC_NUM-1:0] is_allocatable;
  logic               protocol_err;

  // scheduler side: consumes requester flits, drives the link
  modport master (
    input  vc_flit, vc_valid, is_on_off, is_allocatable,
    output vc_ready, data, is_valid, protocol_err
  );

  // requester/downstream side
  modport slave (
    output vc_flit, vc_valid, is_on_off, is_allocatable,
    input  vc_ready, data, is_valid, protocol_err
  );
endinterface

// File: rtl/link_vc_scheduler.sv
// rtl/link_vc_scheduler.sv - round-robin VC flit scheduler onto one router link
module link_vc_scheduler
  import noc_params::*;
#(
  parameter int VC_NUM      = noc_params::VC_NUM,
  parameter bit ALLOC_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  link_vc_scheduler_if.master link_io
);
  localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic {IDLE, ACTIVE} vc_state_e;

  vc_state_e          state_q [VC_NUM];
  vc_state_e          state_d [VC_NUM];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  flit_t              data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [VC_NUM-1:0]  label_ok;
  logic [VC_NUM-1:0]  eligible;
  logic [VC_NUM-1:0]  illegal;
  logic [VC_NUM-1:0]  grant;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;

  // per-VC eligibility: label must fit the packet state; heads also need a free downstream VC
  always_comb begin
    label_ok = '0;
    eligible = '0;
    illegal  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (state_q[v] == IDLE)
        label_ok[v] = (link_io.vc_flit[v].flit_label == HEAD) ||
                      (link_io.vc_flit[v].flit_label == HEADTAIL);
      else
        label_ok[v] = (link_io.vc_flit[v].flit_label == BODY) ||
                      (link_io.vc_flit[v].flit_label == TAIL);
      illegal[v]  = link_io.vc_valid[v] & ~label_ok[v];
      eligible[v] = link_io.vc_valid[v] & link_io.is_on_off[v] & label_ok[v] &
                    ((state_q[v] == ACTIVE) | link_io.is_allocatable[v] | ~ALLOC_CHECK);
    end
  end

  // round-robin pick: first eligible VC scanning upward from rr_ptr with wrap
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(VC_NUM))
        sum = sum - (PTR_W+1)'(VC_NUM);
      idx = sum[PTR_W-1:0];
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any)
      grant[gnt_idx] = 1'b1;
  end

  // next state: packet FSMs, pointer advance, link register load, error pulse
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    valid_d  = gnt_any;
    err_d    = |illegal;
    if (gnt_any) begin
      rr_ptr_d     = (gnt_idx == PTR_W'(VC_NUM - 1)) ? '0 : gnt_idx + PTR_W'(1);
      data_d       = link_io.vc_flit[gnt_idx];
      data_d.vc_id = VC_SIZE'(gnt_idx);
      case (link_io.vc_flit[gnt_idx].flit_label)
        HEAD:    state_d[gnt_idx] = ACTIVE;
        TAIL:    state_d[gnt_idx] = IDLE;
        default: ;
      endcase
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++)
        state_q[v] <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign link_io.vc_ready     = rst ? '0 : grant;
  assign link_io.data         = data_q;
  assign link_io.is_valid     = valid_q;
  assign link_io.protocol_err = err_q;
endmodule
